// File: rtl/irq_dispatch_seq_pkg.sv
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared types and constants for the interrupt dispatch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_REQ     = 2'd2,
        ST_SERVICE = 2'd3
    } state_e;

    localparam logic [1:0] BUS_A = 2'd0;
    localparam logic [1:0] BUS_B = 2'd1;
    localparam logic [1:0] BUS_C = 2'd2;

    localparam int NUM_CHAN_PER_BUS = 9;
    localparam int NUM_CHAN         = 27;

    typedef logic [4:0] vec_t;

    // Highest set flag wins: A over B over C.
    function automatic logic [1:0] bus_idx(input logic [2:0] grp);
        if (grp[2])      return BUS_A;
        else if (grp[1]) return BUS_B;
        else             return BUS_C;
    endfunction

    function automatic vec_t make_vec(input logic [1:0] bus, input logic [3:0] chan);
        return 5'(int'(bus) * NUM_CHAN_PER_BUS + int'(chan));
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_dispatch_seq_if.sv
// ============================================================================
//  Module      : irq_dispatch_seq_if
//  Description : Resolver-side inputs and CPU-side handshake of the dispatcher.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface irq_dispatch_seq_if
    import irq_pkg::*;
#(
    parameter int SPUR_W = 8
);
    logic [2:0]          grp_pend;
    logic [3:0]          chan_code;
    logic                cpu_ack;
    logic                cpu_eoi;
    logic                irq_o;
    vec_t                vec_o;
    logic                vec_valid_o;
    logic [NUM_CHAN-1:0] isr_mask_o;
    logic [SPUR_W-1:0]   spur_cnt_o;
    logic                busy_o;

    modport slave (
        input  grp_pend, chan_code, cpu_ack, cpu_eoi,
        output irq_o, vec_o, vec_valid_o, isr_mask_o, spur_cnt_o, busy_o
    );

    modport master (
        output grp_pend, chan_code, cpu_ack, cpu_eoi,
        input  irq_o, vec_o, vec_valid_o, isr_mask_o, spur_cnt_o, busy_o
    );

endinterface

`default_nettype wire

// File: rtl/irq_dispatch_seq_settle_filter.sv
// ============================================================================
//  Module      : irq_settle_filter
//  Description : Flags a resolver sample that has held for SETTLE_CYC cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_settle_filter #(
    parameter int SETTLE_CYC = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_load,
    input  wire logic       i_track,
    input  wire logic [2:0] i_grp,
    input  wire logic [3:0] i_chan,
    output logic            o_stable,
    output logic [2:0]      o_grp,
    output logic [3:0]      o_chan
);

    localparam logic [3:0] C_SETTLE = 4'(SETTLE_CYC);

    logic [6:0] prev_q, prev_d;
    logic [3:0] cnt_q,  cnt_d;
    logic [6:0] w_sample;

    assign w_sample = {i_grp, i_chan};

    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (i_load) begin
            prev_d = w_sample;
            cnt_d  = 4'd1;
        end else if (i_track) begin
            // At the target the owner captures prev_q this cycle and moves on.
            if (cnt_q == C_SETTLE) begin
                cnt_d = cnt_q;
            end else if (w_sample == prev_q) begin
                cnt_d = cnt_q + 4'd1;
            end else begin
                prev_d = w_sample;
                cnt_d  = 4'd1;
            end
        end else begin
            cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 7'd0;
            cnt_q  <= 4'd0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_stable = i_track && (cnt_q == C_SETTLE);
    assign o_grp    = prev_q[6:4];
    assign o_chan   = prev_q[3:0];

endmodule

`default_nettype wire

// File: rtl/irq_dispatch_seq.sv
// ============================================================================
//  Module      : irq_dispatch_seq
//  Description : Captures a settled resolver winner, raises irq with req/ack,
//                and holds the in-service mask until end-of-interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_dispatch_seq
    import irq_pkg::*;
#(
    parameter int SETTLE_CYC  = 2,
    parameter int ACK_TIMEOUT = 64,
    parameter int SPUR_W      = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    irq_dispatch_seq_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_SETTLE  = ST_SETTLE;
    localparam logic [1:0] S_REQ     = ST_REQ;
    localparam logic [1:0] S_SERVICE = ST_SERVICE;

    localparam int              TMO_W      = $clog2(ACK_TIMEOUT);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]      C_CHAN_MAX = 4'(NUM_CHAN_PER_BUS - 1);
    localparam logic [SPUR_W-1:0] C_SPUR_MAX = '1;

    logic [1:0]          state_q, state_d;
    logic                irq_q,   irq_d;
    vec_t                vec_q,   vec_d;
    logic                valid_q, valid_d;
    logic [NUM_CHAN-1:0] mask_q,  mask_d;
    logic [SPUR_W-1:0]   spur_q,  spur_d;
    logic [TMO_W-1:0]    tmo_q,   tmo_d;

    logic                w_load;
    logic                w_track;
    logic                w_stable;
    logic [2:0]          w_filt_grp;
    logic [3:0]          w_filt_chan;
    logic [SPUR_W-1:0]   w_spur_inc;

    assign w_load     = (state_q == S_IDLE) && (bus.grp_pend != 3'b000);
    assign w_track    = (state_q == S_SETTLE);
    assign w_spur_inc = (spur_q == C_SPUR_MAX) ? spur_q : spur_q + SPUR_W'(1);

    irq_settle_filter #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_track  (w_track),
        .i_grp    (bus.grp_pend),
        .i_chan   (bus.chan_code),
        .o_stable (w_stable),
        .o_grp    (w_filt_grp),
        .o_chan   (w_filt_chan)
    );

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        vec_d   = vec_q;
        valid_d = valid_q;
        mask_d  = mask_q;
        spur_d  = spur_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (w_load) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // A completed settle period takes precedence over a dropped request.
                if (w_stable) begin
                    if (w_filt_chan <= C_CHAN_MAX) begin
                        vec_d   = make_vec(bus_idx(w_filt_grp), w_filt_chan);
                        irq_d   = 1'b1;
                        valid_d = 1'b1;
                        tmo_d   = '0;
                        state_d = S_REQ;
                    end else begin
                        spur_d  = w_spur_inc;
                        state_d = S_IDLE;
                    end
                end else if (bus.grp_pend == 3'b000) begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (bus.cpu_ack) begin
                    irq_d   = 1'b0;
                    mask_d  = NUM_CHAN'(1) << vec_q;
                    state_d = S_SERVICE;
                end else if (tmo_q == C_TMO_LAST) begin
                    irq_d   = 1'b0;
                    valid_d = 1'b0;
                    spur_d  = w_spur_inc;
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (bus.cpu_eoi) begin
                    mask_d  = '0;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
            vec_q   <= '0;
            valid_q <= 1'b0;
            mask_q  <= '0;
            spur_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            mask_q  <= mask_d;
            spur_q  <= spur_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.irq_o       = irq_q;
    assign bus.vec_o       = vec_q;
    assign bus.vec_valid_o = valid_q;
    assign bus.isr_mask_o  = mask_q;
    assign bus.spur_cnt_o  = spur_q;
    assign bus.busy_o      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_irq_dispatch_seq.sv
// ============================================================================
//  Module      : tb_irq_dispatch_seq
//  Description : Directed and randomized checks of irq_dispatch_seq against a
//                timestamp-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_dispatch_seq;

    localparam int SETTLE_CYC  = 2;
    localparam int ACK_TIMEOUT = 4;
    localparam int SPUR_W      = 8;
    localparam int SPUR_MAX    = (1 << SPUR_W) - 1;

    logic clk;
    logic rst;

    irq_dispatch_seq_if #(.SPUR_W(SPUR_W)) bus_if ();

    irq_dispatch_seq #(
        .SETTLE_CYC  (SETTLE_CYC),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .SPUR_W      (SPUR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phases with cycle timestamps rather than counters.
    int          cyc = 0;
    int          m_phase = 0;      // 0 idle, 1 settling, 2 requesting, 3 in service
    logic [6:0]  m_held;
    int          m_run_start;
    int          m_req_start;
    logic        m_irq, m_valid;
    int          m_vec, m_spur;
    logic [26:0] m_mask;
    logic        chk_en = 1'b0;
    int          m_bus, m_chan;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_irq = 0; m_valid = 0; m_vec = 0; m_spur = 0; m_mask = '0;
            chk_en  = 1'b1;
        end else begin
            case (m_phase)
                0: if (bus_if.grp_pend != 0) begin
                    m_held = {bus_if.grp_pend, bus_if.chan_code};
                    m_run_start = cyc;
                    m_phase = 1;
                end
                1: if (cyc - m_run_start == SETTLE_CYC) begin
                    m_bus  = m_held[6] ? 0 : (m_held[5] ? 1 : 2);
                    m_chan = int'(m_held[3:0]);
                    if (m_chan <= 8) begin
                        m_vec = m_bus * 9 + m_chan;
                        m_irq = 1; m_valid = 1; m_req_start = cyc; m_phase = 2;
                    end else begin
                        if (m_spur < SPUR_MAX) m_spur++;
                        m_phase = 0;
                    end
                end else if (bus_if.grp_pend == 0) begin
                    m_phase = 0;
                end else if ({bus_if.grp_pend, bus_if.chan_code} != m_held) begin
                    m_held = {bus_if.grp_pend, bus_if.chan_code};
                    m_run_start = cyc;
                end
                2: if (bus_if.cpu_ack) begin
                    m_irq = 0; m_mask = 27'd1 << m_vec; m_phase = 3;
                end else if (cyc - m_req_start == ACK_TIMEOUT) begin
                    m_irq = 0; m_valid = 0;
                    if (m_spur < SPUR_MAX) m_spur++;
                    m_phase = 0;
                end
                default: if (bus_if.cpu_eoi) begin
                    m_mask = '0; m_valid = 0; m_phase = 0;
                end
            endcase
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_irq",   32'(bus_if.irq_o),       32'(m_irq));
            chk("cmp_valid", 32'(bus_if.vec_valid_o), 32'(m_valid));
            chk("cmp_mask",  32'(bus_if.isr_mask_o),  32'(m_mask));
            chk("cmp_spur",  32'(bus_if.spur_cnt_o),  32'(m_spur));
            chk("cmp_busy",  32'(bus_if.busy_o),      32'(m_phase != 0));
            if (m_valid) chk("cmp_vec", 32'(bus_if.vec_o), 32'(m_vec));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_irq(input string nm);
        int n = 0;
        while (!bus_if.irq_o && n < 8) begin
            tick();
            n++;
        end
        chk({nm, "_irq_rise"}, 32'(bus_if.irq_o), 32'd1);
    endtask

    task automatic capture(input string nm, input logic [2:0] g, input logic [3:0] c,
                           input int exp_vec);
        bus_if.grp_pend  = g;
        bus_if.chan_code = c;
        wait_irq(nm);
        chk({nm, "_vec"}, 32'(bus_if.vec_o), 32'(exp_vec));
        bus_if.grp_pend  = 3'b000;
        bus_if.chan_code = 4'd0;
    endtask

    task automatic ack_eoi(input string nm, input logic [26:0] exp_mask);
        bus_if.cpu_ack = 1'b1;
        tick();
        bus_if.cpu_ack = 1'b0;
        chk({nm, "_mask"}, 32'(bus_if.isr_mask_o), 32'(exp_mask));
        chk({nm, "_irq_low"}, 32'(bus_if.irq_o), 32'd0);
        bus_if.cpu_eoi = 1'b1;
        tick();
        bus_if.cpu_eoi = 1'b0;
        chk({nm, "_mask_clr"}, 32'(bus_if.isr_mask_o), 32'd0);
        chk({nm, "_idle"}, 32'(bus_if.busy_o), 32'd0);
    endtask

    initial begin
        int n_hi;
        rst = 1'b1;
        bus_if.grp_pend = 3'b000; bus_if.chan_code = 4'd0;
        bus_if.cpu_ack  = 1'b0;   bus_if.cpu_eoi   = 1'b0;
        tick(); tick();
        chk("rst_irq",   32'(bus_if.irq_o),       32'd0);
        chk("rst_vec",   32'(bus_if.vec_o),       32'd0);
        chk("rst_valid", 32'(bus_if.vec_valid_o), 32'd0);
        chk("rst_mask",  32'(bus_if.isr_mask_o),  32'd0);
        chk("rst_spur",  32'(bus_if.spur_cnt_o),  32'd0);
        chk("rst_busy",  32'(bus_if.busy_o),      32'd0);
        rst = 1'b0;
        tick();

        // Bus A, channel 4: irq appears on the third edge after the first sample.
        bus_if.grp_pend = 3'b100; bus_if.chan_code = 4'd4;
        tick(); tick();
        chk("a_irq_early", 32'(bus_if.irq_o), 32'd0);
        tick();
        chk("a_irq", 32'(bus_if.irq_o), 32'd1);
        chk("a_vec", 32'(bus_if.vec_o), 32'd4);
        bus_if.grp_pend = 3'b000; bus_if.chan_code = 4'd0;
        ack_eoi("a", 27'h10);

        capture("b", 3'b011, 4'd8, 17);
        ack_eoi("b", 27'h20000);
        capture("c", 3'b001, 4'd8, 26);
        ack_eoi("c", 27'h4000000);

        // Alternating code never settles.
        bus_if.grp_pend = 3'b010;
        for (int i = 0; i < 8; i++) begin
            bus_if.chan_code = (i % 2 == 1) ? 4'd3 : 4'd2;
            tick();
            chk("unstable_no_irq", 32'(bus_if.irq_o), 32'd0);
        end
        capture("unstable", 3'b010, 4'd3, 12);
        ack_eoi("unstable", 27'h1000);

        // Ack timeout after ACK_TIMEOUT request cycles.
        capture("tmo", 3'b100, 4'd1, 1);
        n_hi = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_if.irq_o) n_hi++;
            else break;
        end
        chk("tmo_len",   32'(n_hi),               32'd4);
        chk("tmo_spur",  32'(bus_if.spur_cnt_o),  32'd1);
        chk("tmo_busy",  32'(bus_if.busy_o),      32'd0);
        chk("tmo_valid", 32'(bus_if.vec_valid_o), 32'd0);

        // Ack on the final request cycle wins over the timeout.
        capture("late", 3'b100, 4'd1, 1);
        tick(); tick(); tick();
        bus_if.cpu_ack = 1'b1;
        tick();
        bus_if.cpu_ack = 1'b0;
        chk("late_valid", 32'(bus_if.vec_valid_o), 32'd1);
        chk("late_mask",  32'(bus_if.isr_mask_o),  32'h2);
        chk("late_spur",  32'(bus_if.spur_cnt_o),  32'd1);
        chk("late_busy",  32'(bus_if.busy_o),      32'd1);
        bus_if.cpu_eoi = 1'b1; tick(); bus_if.cpu_eoi = 1'b0;

        // Invalid code: one spurious event every three cycles, then saturation.
        bus_if.grp_pend = 3'b100; bus_if.chan_code = 4'hF;
        tick(); tick(); tick();
        chk("inv_spur", 32'(bus_if.spur_cnt_o), 32'd2);
        chk("inv_irq",  32'(bus_if.irq_o),      32'd0);
        repeat (900) tick();
        chk("sat_spur", 32'(bus_if.spur_cnt_o), 32'd255);
        repeat (30) tick();
        chk("sat_hold", 32'(bus_if.spur_cnt_o), 32'd255);
        bus_if.grp_pend = 3'b000; bus_if.chan_code = 4'd0;
        tick(); tick();

        // Reset while in service.
        capture("rstsvc", 3'b100, 4'd5, 5);
        bus_if.cpu_ack = 1'b1; tick(); bus_if.cpu_ack = 1'b0;
        chk("rstsvc_mask", 32'(bus_if.isr_mask_o), 32'h20);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstsvc_irq",   32'(bus_if.irq_o),       32'd0);
        chk("rstsvc_mask0", 32'(bus_if.isr_mask_o),  32'd0);
        chk("rstsvc_valid", 32'(bus_if.vec_valid_o), 32'd0);
        chk("rstsvc_spur",  32'(bus_if.spur_cnt_o),  32'd0);
        chk("rstsvc_busy",  32'(bus_if.busy_o),      32'd0);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) begin
                bus_if.grp_pend  = 3'($urandom_range(7));
                bus_if.chan_code = ($urandom_range(5) == 0) ? 4'($urandom_range(15))
                                                            : 4'($urandom_range(8));
            end
            bus_if.cpu_ack = ($urandom_range(5) == 0);
            bus_if.cpu_eoi = ($urandom_range(3) == 0);
            rst            = ($urandom_range(199) == 0);
            tick();
        end
        rst = 1'b0;
        bus_if.grp_pend = 3'b000; bus_if.cpu_ack = 1'b0; bus_if.cpu_eoi = 1'b0;
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
